// File: rtl/tl_sensor_cond.sv
// Vehicle-sensor conditioning for the traffic light controller: per street,
// synchronize, debounce, stretch detection by a hold time, and count arrivals.
module tl_sensor_cond #(
    parameter int DEBOUNCE = 4,
    parameter int HOLD     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sa_raw,
    input  logic       sb_raw,
    input  logic       cnt_clr,
    output logic       Ta,
    output logic       Tb,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
);

    typedef enum logic [1:0] {
        ST_ABSENT,
        ST_PRESENT,
        ST_HOLD
    } lane_state_t;

    logic       raw      [2];
    logic       t_flag   [2];
    logic [7:0] arr_cnt  [2];

    assign raw[0] = sa_raw;
    assign raw[1] = sb_raw;
    assign Ta     = t_flag[0];
    assign Tb     = t_flag[1];
    assign cnt_a  = arr_cnt[0];
    assign cnt_b  = arr_cnt[1];

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic        s1, s2, db;
        logic [3:0]  run;
        logic [7:0]  timer, timer_d;
        logic [7:0]  arrivals;
        logic        arrive;
        lane_state_t state, state_d;

        // Synchronizer and debounce: db flips only after DEBOUNCE consecutive disagreeing samples
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1  <= 1'b0;
                s2  <= 1'b0;
                db  <= 1'b0;
                run <= '0;
            end else begin
                s1 <= raw[i];
                s2 <= s1;
                if (s2 == db) begin
                    run <= '0;
                end else if (run == 4'(DEBOUNCE - 1)) begin
                    db  <= ~db;
                    run <= '0;
                end else begin
                    run <= run + 4'd1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state <= ST_ABSENT;
                timer <= '0;
            end else begin
                state <= state_d;
                timer <= timer_d;
            end
        end

        always_comb begin
            state_d = state;
            timer_d = timer;
            arrive  = 1'b0;
            case (state)
                ST_ABSENT: begin
                    if (db) begin
                        state_d = ST_PRESENT;
                        arrive  = 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (!db) begin
                        state_d = ST_HOLD;
                        timer_d = 8'(HOLD);
                    end
                end
                ST_HOLD: begin
                    // A returning vehicle during hold is the same occupancy, not a new arrival
                    if (db) begin
                        state_d = ST_PRESENT;
                        timer_d = '0;
                    end else if (timer == 8'd1) begin
                        state_d = ST_ABSENT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_ABSENT;
                    timer_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                arrivals <= '0;
            end else if (cnt_clr) begin
                arrivals <= '0;
            end else if (arrive && (arrivals != 8'hFF)) begin
                arrivals <= arrivals + 8'd1;
            end
        end

        assign t_flag[i]  = (state != ST_ABSENT);
        assign arr_cnt[i] = arrivals;
    end

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: directed latency scenarios plus random sensor traffic
// compared cycle by cycle against an occupancy-level reference model.
module tb_tl_sensor_cond;

    localparam int DEBOUNCE = 4;
    localparam int HOLD     = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       sa_raw  = 1'b0;
    logic       sb_raw  = 1'b0;
    logic       cnt_clr = 1'b0;
    logic       Ta, Tb;
    logic [7:0] cnt_a, cnt_b;

    int vectors = 0;
    int errors  = 0;

    // Reference model state per lane: sync history, accepted level, occupancy, hold remaining, arrivals
    int m_s1[2], m_s2[2], m_db[2], m_run[2], m_t[2], m_hold[2], m_cnt[2];

    always #5 clk = ~clk;

    tl_sensor_cond #(.DEBOUNCE(DEBOUNCE), .HOLD(HOLD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sa_raw  (sa_raw),
        .sb_raw  (sb_raw),
        .cnt_clr (cnt_clr),
        .Ta      (Ta),
        .Tb      (Tb),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    function automatic logic [17:0] model_vec();
        return {(m_t[0] != 0), (m_t[1] != 0), 8'(m_cnt[0]), 8'(m_cnt[1])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_run[i] = 0;
            m_t[i] = 0; m_hold[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic step_model();
        int raw[2];
        int n_db, n_run, n_t, n_hold;
        bit arr;
        raw[0] = int'(sa_raw);
        raw[1] = int'(sb_raw);
        for (int i = 0; i < 2; i++) begin
            n_db = m_db[i]; n_run = 0; n_t = m_t[i]; n_hold = m_hold[i]; arr = 1'b0;
            if (m_s2[i] != m_db[i]) begin
                if (m_run[i] + 1 == DEBOUNCE) n_db = 1 - m_db[i];
                else n_run = m_run[i] + 1;
            end
            if (m_t[i] == 0) begin
                if (m_db[i] == 1) begin n_t = 1; arr = 1'b1; end
            end else if (m_hold[i] == 0) begin
                if (m_db[i] == 0) n_hold = HOLD;
            end else if (m_db[i] == 1) begin
                n_hold = 0;
            end else if (m_hold[i] == 1) begin
                n_t = 0; n_hold = 0;
            end else begin
                n_hold = m_hold[i] - 1;
            end
            if (cnt_clr) m_cnt[i] = 0;
            else if (arr && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
            m_s2[i] = m_s1[i]; m_s1[i] = raw[i];
            m_db[i] = n_db; m_run[i] = n_run; m_t[i] = n_t; m_hold[i] = n_hold;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step_model();
        @(negedge clk);
    endtask

    // Leaves the bench at a falling edge with reset released; next rising edge is "edge 1"
    task automatic apply_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({Ta, Tb, cnt_a, cnt_b} !== 18'h0) begin
            errors++;
            $display("FAIL async_reset: got Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d, expected all 0", Ta, Tb, cnt_a, cnt_b);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        sa_raw = 1'b1; sb_raw = 1'b1;
        #1;
        vectors++;
        if ({Ta, Tb, cnt_a, cnt_b} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state: got Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d, expected all 0", Ta, Tb, cnt_a, cnt_b);
        end
        sa_raw = 1'b0; sb_raw = 1'b0;
        apply_reset();
    endtask

    task automatic test_clean_detect();
        apply_reset();
        sa_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            vectors++;
            if (Ta !== (e >= 7)) begin
                errors++;
                $display("FAIL clean_rise e%0d: got Ta=%b expected %b", e, Ta, (e >= 7));
            end
        end
        vectors++;
        if ({Tb, cnt_a, cnt_b} !== {1'b0, 8'd1, 8'd0}) begin
            errors++;
            $display("FAIL clean_counts: got Tb=%b cnt_a=%0d cnt_b=%0d expected 0/1/0", Tb, cnt_a, cnt_b);
        end
        sa_raw = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            vectors++;
            if ({Ta, cnt_a} !== {(e < 15), 8'd1}) begin
                errors++;
                $display("FAIL clean_fall e%0d: got Ta=%b cnt_a=%0d expected %b/1", e, Ta, cnt_a, (e < 15));
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        for (int e = 1; e <= 25; e++) begin
            sb_raw = (e <= 3);
            tick();
            vectors++;
            if ({Tb, cnt_b} !== 9'h0) begin
                errors++;
                $display("FAIL glitch_reject e%0d: got Tb=%b cnt_b=%0d expected 0/0", e, Tb, cnt_b);
            end
        end
        for (int e = 1; e <= 25; e++) begin
            sb_raw = (e <= 4);
            tick();
            vectors++;
            if (Tb !== (e >= 7 && e < 19)) begin
                errors++;
                $display("FAIL glitch_accept e%0d: got Tb=%b expected %b", e, Tb, (e >= 7 && e < 19));
            end
        end
        vectors++;
        if (cnt_b !== 8'd1) begin
            errors++;
            $display("FAIL glitch_count: got cnt_b=%0d expected 1", cnt_b);
        end
    endtask

    task automatic test_retrigger();
        apply_reset();
        sa_raw = 1'b1;
        repeat (10) tick();
        for (int e = 1; e <= 30; e++) begin
            sa_raw = !(e <= 6);
            tick();
            vectors++;
            if ({Ta, cnt_a} !== {1'b1, 8'd1} || {Ta, Tb, cnt_a, cnt_b} !== model_vec()) begin
                errors++;
                $display("FAIL retrigger e%0d: got Ta=%b cnt_a=%0d expected 1/1 (model %h)", e, Ta, cnt_a, model_vec());
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int k = 1; k <= 260; k++) begin
            for (int e = 1; e <= 28; e++) begin
                sa_raw = (e <= 6);
                tick();
                vectors++;
                if ({Ta, Tb, cnt_a, cnt_b} !== model_vec()) begin
                    errors++;
                    $display("FAIL saturate k%0d e%0d: got Ta=%b cnt_a=%0d expected %h", k, e, Ta, cnt_a, model_vec());
                end
            end
        end
        vectors++;
        if (cnt_a !== 8'd255) begin
            errors++;
            $display("FAIL saturate_255: got cnt_a=%0d expected 255", cnt_a);
        end
        sa_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cnt_clr = (e == 7);
            tick();
        end
        cnt_clr = 1'b0;
        vectors++;
        if ({Ta, cnt_a} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL clear_vs_arrival: got Ta=%b cnt_a=%0d expected 1/0", Ta, cnt_a);
        end
        sa_raw = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        sa_raw = 1'b1;
        repeat (10) tick();
        sa_raw = 1'b0;
        repeat (9) tick();
        vectors++;
        if (Ta !== 1'b1) begin
            errors++;
            $display("FAIL mid_hold_pre: got Ta=%b expected 1", Ta);
        end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({Ta, cnt_a} !== 9'h0) begin
            errors++;
            $display("FAIL mid_hold_reset: got Ta=%b cnt_a=%0d expected 0/0", Ta, cnt_a);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            vectors++;
            if (Ta !== 1'b0) begin
                errors++;
                $display("FAIL mid_hold_after e%0d: got Ta=%b expected 0", e, Ta);
            end
        end
        sa_raw = 1'b1;
        repeat (3) tick();
        apply_reset();
        for (int e = 1; e <= 10; e++) begin
            tick();
            vectors++;
            if (Ta !== (e >= 7)) begin
                errors++;
                $display("FAIL mid_debounce_restart e%0d: got Ta=%b expected %b", e, Ta, (e >= 7));
            end
        end
        sa_raw = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_independence();
        apply_reset();
        for (int e = 1; e <= 45; e++) begin
            sa_raw = (e <= 20);
            sb_raw = (e >= 4 && e <= 25);
            tick();
            vectors++;
            if ({Ta, Tb} !== {(e >= 7 && e < 35), (e >= 10 && e < 40)}) begin
                errors++;
                $display("FAIL independence e%0d: got Ta=%b Tb=%b expected %b %b",
                         e, Ta, Tb, (e >= 7 && e < 35), (e >= 10 && e < 40));
            end
        end
    endtask

    task automatic test_random();
        int dur[2];
        apply_reset();
        dur[0] = 0; dur[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            if (dur[0] == 0) begin sa_raw = ~sa_raw; dur[0] = int'($urandom_range(1, 30)); end
            if (dur[1] == 0) begin sb_raw = ~sb_raw; dur[1] = int'($urandom_range(1, 30)); end
            dur[0]--; dur[1]--;
            cnt_clr = ($urandom_range(0, 99) == 0);
            tick();
            vectors++;
            if ({Ta, Tb, cnt_a, cnt_b} !== model_vec()) begin
                errors++;
                $display("FAIL random n%0d: got Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d expected %h",
                         n, Ta, Tb, cnt_a, cnt_b, model_vec());
            end
        end
        cnt_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_detect();
        test_glitch();
        test_retrigger();
        test_saturation();
        test_reset_mid();
        test_independence();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tl_sensor_cond.md
TL_SENSOR_COND -- requirements
Module: tl_sensor_cond

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, meaning consecutive synchronized cycles a raw level must persist to be accepted (legal 2..15).
REQ-002 The block SHALL have parameter HOLD, default 8, meaning cycles the traffic flag stays high after debounced detection drops (legal 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sa_raw, input, 1 bit: raw, asynchronous, bouncy vehicle sensor on street A.
REQ-006 The block SHALL have port sb_raw, input, 1 bit: raw vehicle sensor on street B.
REQ-007 The block SHALL have port cnt_clr, input, 1 bit: synchronous clear of both arrival counters.
REQ-008 The block SHALL have port Ta, output, 1 bit: conditioned traffic-present flag for street A, fed directly to the traffic light controller's Ta.
REQ-009 The block SHALL have port Tb, output, 1 bit: conditioned traffic-present flag for street B, fed to the controller's Tb.
REQ-010 The block SHALL have port cnt_a, output, 8 bits: saturating arrival count for street A.
REQ-011 The block SHALL have port cnt_b, output, 8 bits: saturating arrival count for street B.

Function
REQ-012 Each lane (A, B) SHALL be an independent, identical channel; nothing below couples the lanes.
REQ-013 Each raw input SHALL pass through a two-flop synchronizer (s1, s2) before any other logic.
REQ-014 Each lane SHALL keep a debounced level db and a run counter: counter clears on any edge where s2 == db, increments where s2 != db, and on the edge it would reach DEBOUNCE db toggles and counter clears.
REQ-015 A synchronized pulse or gap shorter than DEBOUNCE cycles SHALL leave db unchanged; exactly DEBOUNCE cycles SHALL toggle db.
REQ-016 Each lane SHALL run a registered FSM with states ABSENT (T=0), PRESENT (T=1), HOLD (T=1); T is decoded from the registered state only (glitch-free).
REQ-017 ABSENT -> PRESENT when db==1; PRESENT -> HOLD when db==0, loading hold timer with HOLD; HOLD -> PRESENT when db==1 (timer discarded); HOLD -> ABSENT when db==0 and timer==1; otherwise timer decrements each edge in HOLD.
REQ-018 Rise latency: raw held 1 from before edge 1 SHALL give T=1 after edge DEBOUNCE+3 (edge 7 at defaults).
REQ-019 Fall latency: raw held 0 from before edge 1 (state PRESENT) SHALL give T=0 after edge DEBOUNCE+3+HOLD (edge 15 at defaults).
REQ-020 The arrival counter SHALL increment by 1 only on the ABSENT -> PRESENT transition; HOLD -> PRESENT is not a new arrival.
REQ-021 The arrival counter SHALL saturate at 255 and not wrap.
REQ-022 cnt_clr SHALL zero both counters on the next edge; when cnt_clr coincides with an arrival, clear wins (result 0).
REQ-023 cnt_clr SHALL NOT affect synchronizers, db, FSM or T.

Reset
REQ-024 reset_n low SHALL immediately, without a clock, force s1, s2, db, run counters, hold timers = 0, FSM = ABSENT, Ta=Tb=0, cnt_a=cnt_b=0.
REQ-025 Reset asserted mid-HOLD or mid-debounce SHALL abandon the operation; after release, behaviour SHALL match a fresh start with the then-current raw levels (raw already 1 at release -> T=1 after edge DEBOUNCE+3 after release).

Verification
REQ-026 Clean detect: reset, release, sa_raw=1 before edge 1 -> Ta=1 after edge 7, cnt_a=1, Tb=0, cnt_b=0.
REQ-027 Glitch reject: sb_raw high for 3 clocks then low -> Tb stays 0, cnt_b stays 0; high for 4 clocks -> Tb=1 after edge 7, then Tb=0 after edge 15+4, cnt_b=1.
REQ-028 Hold re-trigger: Ta=1, sa_raw drops; sa_raw returns 1 while in HOLD -> Ta never drops, cnt_a unchanged.
REQ-029 Saturation and clear: 260 separated arrivals on A -> cnt_a=255; pulse cnt_clr on the same edge as arrival 261 -> cnt_a=0 while Ta=1.
REQ-030 Reset mid-operation: reset_n low during HOLD -> Ta=0 and cnt_a=0 immediately, before the next clock edge; release with sa_raw=0 -> Ta stays 0.
REQ-031 Independence: sa_raw and sb_raw toggled with offset phases -> each of Ta and Tb matches its own latency rules exactly.
